// File: rtl/hex_scroller_pkg.sv
// Shared character codes and the active-low seven-segment table for the scrolling display.
package hex_scroller_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned SEG_W  = 7;

    localparam logic [CODE_W-1:0] CH_0     = 4'd0;
    localparam logic [CODE_W-1:0] CH_1     = 4'd1;
    localparam logic [CODE_W-1:0] CH_2     = 4'd2;
    localparam logic [CODE_W-1:0] CH_3     = 4'd3;
    localparam logic [CODE_W-1:0] CH_4     = 4'd4;
    localparam logic [CODE_W-1:0] CH_5     = 4'd5;
    localparam logic [CODE_W-1:0] CH_6     = 4'd6;
    localparam logic [CODE_W-1:0] CH_7     = 4'd7;
    localparam logic [CODE_W-1:0] CH_8     = 4'd8;
    localparam logic [CODE_W-1:0] CH_9     = 4'd9;
    localparam logic [CODE_W-1:0] CH_A     = 4'd10;
    localparam logic [CODE_W-1:0] CH_B     = 4'd11;
    localparam logic [CODE_W-1:0] CH_C     = 4'd12;
    localparam logic [CODE_W-1:0] CH_D     = 4'd13;
    localparam logic [CODE_W-1:0] CH_E     = 4'd14;
    localparam logic [CODE_W-1:0] CH_BLANK = 4'd15;

    // Index 15 (blank) is leftmost; bit 0 of each entry is segment a, 0 = lit.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h7F, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational character-code to active-low segment decoder.
module seg7_decode
    import hex_scroller_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    assign seg = SEG_TABLE[code];

endmodule

// File: rtl/hex_scroller.sv
// Scrolls a fixed character message across a row of seven-segment digits,
// automatically from a prescaler or by a synchronised manual step button.
module hex_scroller
    import hex_scroller_pkg::*;
#(
    parameter int unsigned        CLK_HZ     = 50000000,
    parameter int unsigned        TICK_HZ    = 1,
    parameter int unsigned        NUM_DIGITS = 6,
    parameter int unsigned        MSG_LEN    = 8,
    parameter logic [4*MSG_LEN-1:0] MSG      = {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK,
                                                CH_0, CH_1, CH_E, CH_D}
)(
    input  logic                         CLOCK_50,
    input  logic                         Resetn,
    input  logic                         run,
    input  logic                         dir,
    input  logic                         step_n,
    output logic [7*NUM_DIGITS-1:0]      HEX,
    output logic [$clog2(MSG_LEN)-1:0]   pos,
    output logic                         tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned POS_W = $clog2(MSG_LEN);
    localparam int unsigned IDX_W = $clog2(MSG_LEN + NUM_DIGITS) + 1;

    logic [CNT_W-1:0]        cnt;
    logic                    cnt_wrap_c;
    logic                    step_s1;
    logic                    step_s2;
    logic                    step_prev;
    logic                    step_edge_c;
    logic                    advance_c;
    logic [POS_W-1:0]        pos_next_c;
    logic [7*NUM_DIGITS-1:0] seg_all_c;

    assign cnt_wrap_c = (cnt == CNT_W'(DIV - 1));
    assign tick       = run & cnt_wrap_c;

    // Prescaler: free-runs while run=1, holds while paused.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt_wrap_c ? '0 : cnt + CNT_W'(1);
        end
    end

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            step_s1   <= 1'b1;
            step_s2   <= 1'b1;
            step_prev <= 1'b1;
        end else begin
            step_s1   <= step_n;
            step_s2   <= step_s1;
            step_prev <= step_s2;
        end
    end

    assign step_edge_c = step_prev & ~step_s2;
    assign advance_c   = tick | (step_edge_c & ~run);

    always_comb begin
        pos_next_c = pos;
        if (advance_c) begin
            if (dir) begin
                pos_next_c = (pos == '0) ? POS_W'(MSG_LEN - 1) : pos - POS_W'(1);
            end else begin
                pos_next_c = (pos == POS_W'(MSG_LEN - 1)) ? '0 : pos + POS_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            pos <= '0;
        end else begin
            pos <= pos_next_c;
        end
    end

    // Per-digit offset is reduced at elaboration so one conditional subtract wraps the index.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam int unsigned OFF = (NUM_DIGITS - 1 - k) % MSG_LEN;

        logic [IDX_W-1:0]  sum_c;
        logic [IDX_W-1:0]  idx_c;
        logic [CODE_W-1:0] code_c;
        logic [SEG_W-1:0]  seg_c;

        assign sum_c = IDX_W'(pos) + IDX_W'(OFF);
        assign idx_c = (sum_c >= IDX_W'(MSG_LEN)) ? sum_c - IDX_W'(MSG_LEN) : sum_c;

        always_comb begin
            code_c = CH_BLANK;
            for (int i = 0; i < MSG_LEN; i++) begin
                if (idx_c == IDX_W'(i)) begin
                    code_c = MSG[4*i +: 4];
                end
            end
        end

        seg7_decode u_seg (
            .code (code_c),
            .seg  (seg_c)
        );

        assign seg_all_c[7*k +: 7] = seg_c;
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            HEX <= '1;
        end else begin
            HEX <= seg_all_c;
        end
    end

endmodule

// File: tb/tb_hex_scroller.sv
// Scoreboard bench for hex_scroller: expected pos events are queued by the stimulus
// thread and checked by a monitor whenever pos changes; HEX is checked one cycle later.
module tb_hex_scroller;

    logic        CLOCK_50;
    logic        Resetn;
    logic        run;
    logic        dir;
    logic        step_n;
    logic [27:0] HEX;
    logic [2:0]  pos;
    logic        tick;

    hex_scroller #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .NUM_DIGITS (4),
        .MSG_LEN    (6),
        .MSG        (24'hFF01ED)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .run      (run),
        .dir      (dir),
        .step_n   (step_n),
        .HEX      (HEX),
        .pos      (pos),
        .tick     (tick)
    );

    typedef struct {
        int         cyc;
        logic [2:0] pos;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Message d,E,1,0,blank,blank; leftmost digit shows MSG[pos].
    function automatic logic [27:0] win_of(input logic [2:0] p);
        case (p)
            3'd0:    win_of = {7'h21, 7'h06, 7'h79, 7'h40};
            3'd1:    win_of = {7'h06, 7'h79, 7'h40, 7'h7F};
            3'd2:    win_of = {7'h79, 7'h40, 7'h7F, 7'h7F};
            3'd3:    win_of = {7'h40, 7'h7F, 7'h7F, 7'h21};
            3'd4:    win_of = {7'h7F, 7'h7F, 7'h21, 7'h06};
            3'd5:    win_of = {7'h7F, 7'h21, 7'h06, 7'h79};
            default: win_of = 28'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) cycle();
    endtask

    task automatic expect_pos(input int c, input logic [2:0] p);
        ev_t e;
        e.cyc = c;
        e.pos = p;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expected event per observed pos change.
    initial begin
        logic [2:0]  prev_pos;
        logic        hex_pend;
        logic [27:0] hex_exp;
        ev_t         ev;
        prev_pos = 3'd0;
        hex_pend = 1'b0;
        hex_exp  = '0;
        forever begin
            @(negedge CLOCK_50);
            if (hex_pend) begin
                check("hex_window", 32'(HEX), 32'(hex_exp));
                hex_pend = 1'b0;
            end
            if (Resetn && (pos !== prev_pos)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pos_unexpected: got %0d expected %0d held (cycle %0d)",
                             pos, prev_pos, cyc);
                end else begin
                    ev = exp_q.pop_front();
                    check("pos_value", 32'(pos), 32'(ev.pos));
                    check("pos_cycle", 32'(cyc), 32'(ev.cyc));
                    hex_exp  = win_of(ev.pos);
                    hex_pend = 1'b1;
                end
            end
            prev_pos = pos;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int s;
        Resetn = 1'b0;
        run    = 1'b1;
        dir    = 1'b0;
        step_n = 1'b1;
        repeat (3) cycle();
        check("reset_pos",  32'(pos),  32'd0);
        check("reset_hex",  32'(HEX),  32'hFFFFFFF);
        check("reset_tick", 32'(tick), 32'd0);

        // Automatic scrolling left, wrapping 5 -> 0.
        base   = cyc;
        Resetn = 1'b1;
        for (int k = 1; k <= 6; k++) expect_pos(base + 10*k, 3'(k % 6));
        cycle();
        check("first_window", 32'(HEX), 32'(win_of(3'd0)));
        wait_to(base + 8);
        check("tick_early", 32'(tick), 32'd0);
        cycle();
        check("tick_cnt9", 32'(tick), 32'd1);

        // Flip direction in the tick cycle: 0 -> 5, then 5 -> 4.
        wait_to(base + 69);
        check("tick_flip", 32'(tick), 32'd1);
        dir = 1'b1;
        expect_pos(base + 70, 3'd5);
        expect_pos(base + 80, 3'd4);

        // Step pulses are ignored while running.
        wait_to(base + 72);
        step_n = 1'b0;
        wait_to(base + 76);
        step_n = 1'b1;

        // Pause with cnt=4, pos=4.
        wait_to(base + 84);
        run = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (i % 10 == 0) check("tick_paused", 32'(tick), 32'd0);
        end
        check("pos_paused", 32'(pos), 32'd4);

        // Held step while paused: one advance, on the third edge.
        s      = cyc;
        step_n = 1'b0;
        expect_pos(s + 3, 3'd3);
        wait_to(s + 20);
        step_n = 1'b1;
        wait_to(s + 25);
        check("pos_before_reset", 32'(pos), 32'd3);

        // Asynchronous reset with pos=3, cnt=4.
        run    = 1'b1;
        Resetn = 1'b0;
        #1;
        check("areset_pos",  32'(pos),  32'd0);
        check("areset_hex",  32'(HEX),  32'hFFFFFFF);
        check("areset_tick", 32'(tick), 32'd0);
        repeat (2) cycle();

        // After release the count restarts from 0, not 4.
        base   = cyc;
        dir    = 1'b0;
        Resetn = 1'b1;
        expect_pos(base + 10, 3'd1);
        cycle();
        check("rel_window", 32'(HEX), 32'(win_of(3'd0)));
        wait_to(base + 8);
        check("rel_tick_early", 32'(tick), 32'd0);
        cycle();
        check("rel_tick_cnt9", 32'(tick), 32'd1);

        // Pause at cnt=3 for 20 cycles; tick resumes 6 edges after restart.
        wait_to(base + 13);
        run = 1'b0;
        wait_to(base + 33);
        run = 1'b1;
        expect_pos(base + 40, 3'd2);
        wait_to(base + 38);
        check("resume_tick_early", 32'(tick), 32'd0);
        cycle();
        check("resume_tick", 32'(tick), 32'd1);

        wait_to(base + 45);
        check("events_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_scroller.md
HEX_SCROLLER -- requirements
Module: hex_scroller

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, scroll rate in Hz; DIV = CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Parameter NUM_DIGITS, default 6, number of seven-segment digits driven; range 1..8.
REQ-004 Parameter MSG_LEN, default 8, message length in characters; MSG_LEN >= 2.
REQ-005 Parameter MSG, default {F,F,F,F,0,1,E,d}, packed 4*MSG_LEN bits of character codes, element 0 in bits [3:0].
REQ-006 CLOCK_50  input  1  single clock; all state on its rising edge.
REQ-007 Resetn  input  1  reset, asynchronous, active-low.
REQ-008 run  input  1  1 = automatic scrolling, 0 = paused.
REQ-009 dir  input  1  0 = scroll left (pos increments), 1 = scroll right (pos decrements).
REQ-010 step_n  input  1  active-low pushbutton, asynchronous to CLOCK_50; manual single step while paused.
REQ-011 HEX  output  7*NUM_DIGITS  segments, active-low; digit k in bits [7k+6:7k], bit 0 = segment a; digit NUM_DIGITS-1 is leftmost.
REQ-012 pos  output  clog2(MSG_LEN)  current window start index into MSG.
REQ-013 tick  output  1  one-cycle pulse at each prescaler wrap.

Function
REQ-014 Prescaler cnt SHALL count 0..DIV-1 while run=1 and wrap to 0 after DIV-1; it SHALL hold its value while run=0.
REQ-015 tick SHALL be 1 exactly in cycles where run=1 and cnt=DIV-1, registered-free (combinational from cnt and run).
REQ-016 On a tick, pos SHALL advance at that edge: dir=0 -> (pos+1) mod MSG_LEN; dir=1 -> (pos+MSG_LEN-1) mod MSG_LEN; dir sampled at the same edge.
REQ-017 step_n SHALL pass a two-flop synchroniser; a falling edge is detected when the second stage is 0 and its previous value was 1.
REQ-018 A detected step edge while run=0 SHALL advance pos by one in direction dir; pos updates on the third rising edge counting the edge that first samples step_n low.
REQ-019 Step edges while run=1 SHALL be ignored; holding step_n low SHALL produce exactly one advance.
REQ-020 pos SHALL never change by more than one position per cycle.
REQ-021 Digit k SHALL show MSG[(pos + NUM_DIGITS-1-k) mod MSG_LEN] decoded to segments; wrap through MSG_LEN-1 -> 0 is continuous.
REQ-022 HEX SHALL be registered: one cycle latency from a pos change to the matching HEX value.
REQ-023 Character codes: 0-9 digits, 10 A, 11 b, 12 C, 13 d, 14 E, 15 blank (all segments 1).

Reset
REQ-024 Resetn=0 SHALL immediately force cnt=0, pos=0, synchroniser and edge flops to 1, HEX all ones (all segments off); tick=0.
REQ-025 Reset assertion mid-count or mid-step SHALL discard the pending tick or step; first display of window 0 SHALL appear one cycle after Resetn release.

Structure
REQ-026 Package hex_scroller_pkg SHALL hold the character-code constants (CH_0..CH_9, CH_A, CH_B, CH_C, CH_D, CH_E, CH_BLANK) and the 16-entry active-low segment table.
REQ-027 Sub-module seg7_decode (4-bit code in, 7-bit active-low segments out, combinational) SHALL be instantiated NUM_DIGITS times.
REQ-028 Modulo index arithmetic SHALL use widths wide enough for pos + NUM_DIGITS - 1 without overflow; no division in hardware.

Verification (CLK_HZ=10, TICK_HZ=1 -> DIV=10, NUM_DIGITS=4, MSG_LEN=6, MSG = d,E,1,0,blank,blank)
REQ-029 Release Resetn, run=1, dir=0 -> tick on cycle 10 (cnt=9), pos 0->1, HEX next cycle = {E,1,0,blank} left to right.
REQ-030 Wrap: pos=5 with dir=0 -> tick -> pos=0; pos=0 with dir=1 -> tick -> pos=5, leftmost digit blank, digit 0 = 1.
REQ-031 run=0 for 50 cycles -> cnt frozen, tick never 1, pos constant; then step_n low for 20 cycles -> pos +1 exactly once on third edge.
REQ-032 run=1 with step_n pulsed low -> pos changes only on ticks; dir flipped in the tick cycle -> new direction applied.
REQ-033 Resetn asserted with pos=3, cnt=4 -> pos=0, cnt=0, HEX all ones, tick=0 before the next clock edge.
